// File: rtl/mult_lut_seq_ctrl_pkg.sv
// Shared definitions for the sequential LUT multiplier: FSM state encoding
// and the width of one multiplier digit consumed per RUN cycle.
package mult_lut_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DIGIT_W = 2;

endpackage

// File: rtl/mult_lut_digit.sv
// One 2-bit digit slice of the LUT multiplier: selects 0, A, 2A or 3A
// according to the multiplier digit D.
module mult_lut_digit
    import mult_lut_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]   A,
    input  logic [DIGIT_W-1:0] D,
    output logic [WIDTH+1:0]   P
);

    logic [WIDTH+1:0] aOne;
    logic [WIDTH+1:0] aTwo;

    assign aOne = {2'b00, A};
    assign aTwo = {1'b0, A, 1'b0};

    always_comb begin
        P = '0;
        case (D)
            2'd0:    P = '0;
            2'd1:    P = aOne;
            2'd2:    P = aTwo;
            default: P = aTwo + aOne;
        endcase
    end

endmodule

// File: rtl/mult_lut_seq_ctrl.sv
// Sequencing controller for the LUT multiplier: reuses one digit slice over
// up to WIDTH/2 cycles, with valid/ready input and valid/ack output handshakes.
module mult_lut_seq_ctrl
    import mult_lut_seq_ctrl_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iValid,
    output logic               oReady,
    input  logic [WIDTH-1:0]   iDato_A,
    input  logic [WIDTH-1:0]   iDato_B,
    output logic               oValid,
    input  logic               iAck,
    output logic [2*WIDTH-1:0] oResult,
    output logic               oBusy
);

    localparam int CNT_W = $clog2(WIDTH/2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH/2 - 1);

    state_e             state_q;
    logic               ready_q, valid_q, busy_q;
    logic [2*WIDTH-1:0] result_q;

    logic [WIDTH-1:0]   rA_q, rA_d;
    logic [WIDTH-1:0]   rB_q, rB_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH+1:0]   partial;
    logic [2*WIDTH-1:0] partialExt;
    logic [CNT_W:0]     shAmt;
    logic [2*WIDTH-1:0] accSum;
    logic               lastStep;

    mult_lut_digit #(.WIDTH(WIDTH)) uDigit (
        .A(rA_q),
        .D(rB_q[DIGIT_W-1:0]),
        .P(partial)
    );

    // Each digit is worth 4^count, so the partial product shifts by 2*count bits.
    assign partialExt = {{(2*WIDTH-(WIDTH+2)){1'b0}}, partial};
    assign shAmt      = {count_q, 1'b0};
    assign accSum     = acc_q + (partialExt << shAmt);
    assign lastStep   = (count_q == LAST_CNT) ||
                        (EARLY_EXIT && ((rB_q >> DIGIT_W) == '0));

    always_comb begin
        rA_d    = rA_q;
        rB_d    = rB_q;
        count_d = count_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (iValid) begin
                    rA_d    = iDato_A;
                    rB_d    = iDato_B;
                    count_d = '0;
                    acc_d   = '0;
                end
            end
            ST_RUN: begin
                acc_d   = accSum;
                rB_d    = rB_q >> DIGIT_W;
                count_d = lastStep ? count_q : count_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rA_q    <= '0;
            rB_q    <= '0;
            count_q <= '0;
            acc_q   <= '0;
        end else begin
            rA_q    <= rA_d;
            rB_q    <= rB_d;
            count_q <= count_d;
            acc_q   <= acc_d;
        end
    end

    // Handshake outputs are registered alongside the state so no input reaches them combinationally.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (iValid) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (lastStep) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        valid_q  <= 1'b1;
                        result_q <= accSum;
                    end
                end
                ST_DONE: begin
                    if (iAck) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign oReady  = ready_q;
    assign oValid  = valid_q;
    assign oBusy   = busy_q;
    assign oResult = result_q;

endmodule

// File: tb/tb_mult_lut_seq_ctrl.sv
// Bench for mult_lut_seq_ctrl: one instance per EARLY_EXIT setting, directed
// steps plus random operands, results checked through per-instance queues.
module tb_mult_lut_seq_ctrl;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  vld = '0;
    logic [1:0]  ack = '0;
    logic [1:0]  rdy, ov, bsy;
    logic [15:0] opA [2];
    logic [15:0] opB [2];
    logic [31:0] res [2];

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_lut_seq_ctrl #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut0 (
        .Clock(clk), .Reset(rst),
        .iValid(vld[0]), .oReady(rdy[0]),
        .iDato_A(opA[0]), .iDato_B(opB[0]),
        .oValid(ov[0]), .iAck(ack[0]),
        .oResult(res[0]), .oBusy(bsy[0])
    );

    mult_lut_seq_ctrl #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut1 (
        .Clock(clk), .Reset(rst),
        .iValid(vld[1]), .oReady(rdy[1]),
        .iDato_A(opA[1]), .iDato_B(opB[1]),
        .oValid(ov[1]), .iAck(ack[1]),
        .oResult(res[1]), .oBusy(bsy[1])
    );

    // Reference latency: full 8 digits, or up to the highest nonzero B digit.
    function automatic int expLat(input logic [15:0] b, input bit ee);
        int l;
        if (!ee) return 8;
        l = 1;
        for (int i = 0; i < 8; i++)
            if (b[2*i +: 2] != 2'b00) l = i + 1;
        return l;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called #1 after an edge; the accept happens on the next rising edge.
    task automatic applyStimulus(input int s, input logic [15:0] a, input logic [15:0] b, input bit keepValid);
        exp_t e;
        e.res = 32'(a) * 32'(b);
        e.lat = expLat(b, s == 1);
        if (s == 0) q0.push_back(e); else q1.push_back(e);
        opA[s] = a;
        opB[s] = b;
        vld[s] = 1'b1;
        checkOutput("ready_before_accept", 32'(rdy[s]), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("busy_after_accept", 32'(bsy[s]), 32'd1);
        if (!keepValid) vld[s] = 1'b0;
    endtask

    task automatic drainResult(input int s, input int ackDelay);
        exp_t e;
        int   lat;
        bit   got;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (ov[s]) got = 1'b1;
        end
        checkOutput("valid_timeout", 32'(got), 32'd1);
        if (s == 0) begin
            checkOutput("sb_size", 32'(q0.size()), 32'd1);
            e = q0.pop_front();
        end else begin
            checkOutput("sb_size", 32'(q1.size()), 32'd1);
            e = q1.pop_front();
        end
        checkOutput("latency", 32'(lat), 32'(e.lat));
        checkOutput("result", res[s], e.res);
        for (int i = 0; i < ackDelay; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_valid", 32'(ov[s]), 32'd1);
            checkOutput("hold_result", res[s], e.res);
        end
        ack[s] = 1'b1;
        @(posedge clk);
        #1;
        ack[s] = 1'b0;
        checkOutput("ack_valid_low", 32'(ov[s]), 32'd0);
        checkOutput("ack_ready_high", 32'(rdy[s]), 32'd1);
    endtask

    initial begin
        opA[0] = '0; opA[1] = '0;
        opB[0] = '0; opB[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            checkOutput("reset_ready", 32'(rdy[s]), 32'd1);
            checkOutput("reset_valid", 32'(ov[s]), 32'd0);
            checkOutput("reset_busy", 32'(bsy[s]), 32'd0);
            checkOutput("reset_result", res[s], 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(0, 16'd3, 16'd5, 1'b0);
        drainResult(0, 0);

        // Mid-RUN async reset must discard the earlier result of 15 too.
        opA[0] = 16'h1234;
        opB[0] = 16'hFFFF;
        vld[0] = 1'b1;
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrun_reset_valid", 32'(ov[0]), 32'd0);
        checkOutput("midrun_reset_ready", 32'(rdy[0]), 32'd1);
        checkOutput("midrun_reset_result", res[0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("post_reset_valid", 32'(ov[0]), 32'd0);
        checkOutput("post_reset_result", res[0], 32'd0);

        applyStimulus(0, 16'hFFFF, 16'hFFFF, 1'b0);
        drainResult(0, 5);
        applyStimulus(1, 16'hFFFF, 16'hFFFF, 1'b0);
        drainResult(1, 0);

        applyStimulus(1, 16'hABCD, 16'h0000, 1'b0);
        drainResult(1, 1);
        applyStimulus(1, 16'd7, 16'h0003, 1'b0);
        drainResult(1, 0);
        applyStimulus(1, 16'h00F1, 16'h0100, 1'b0);
        drainResult(1, 2);

        // iValid stays high with new operands through RUN and DONE; the ack edge
        // only returns to IDLE and the pending request is accepted one edge later.
        applyStimulus(1, 16'd5, 16'hFFFF, 1'b1);
        opA[1] = 16'd9;
        opB[1] = 16'd9;
        drainResult(1, 0);
        checkOutput("ack_and_valid_not_busy", 32'(bsy[1]), 32'd0);
        applyStimulus(1, 16'd9, 16'd9, 1'b0);
        drainResult(1, 0);

        for (int i = 0; i < 1000; i++) begin
            int          s;
            logic [15:0] a;
            logic [15:0] b;
            s = i % 2;
            a = 16'($urandom);
            b = 16'($urandom);
            if ((i % 4) >= 2) b = b >> $urandom_range(0, 15);
            applyStimulus(s, a, b, 1'b0);
            drainResult(s, $urandom_range(0, 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
